// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the data-memory access unit.
// Word-addressed memory: word index = byte address [MemAddrWidth+1:2].
package mem_access_unit_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned MemAddrWidth = 10;
    localparam int unsigned ADDR_W       = MemAddrWidth + 2;

    typedef logic [XLEN-1:0] Register;
    typedef logic            Signal;

    localparam Signal ENABLE  = 1'b1;
    localparam Signal DISABLE = 1'b0;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } AccessSize;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } MauState;

    // Halfwords need even addresses; words need addr[1:0] == 0.
    function automatic logic is_misaligned(input AccessSize size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = addr_lo[0];
            default:   is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module mau_lane_align
    import mem_access_unit_pkg::*;
(
    input  Register    rdata,
    input  Register    wdata,
    input  logic [1:0] addr_lo,
    input  AccessSize  size,
    input  logic       is_unsigned,
    output Register    load_data,
    output Register    store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[7:0];
        half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data  = rdata;
        store_word = wdata;

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        case (size)
            SIZE_BYTE: begin
                load_data  = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                store_word = rdata;
                case (addr_lo)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                load_data  = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
                store_word = rdata;
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0]  = wdata[15:0];
                end
            end
            default: begin
                load_data  = rdata;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data memory: sub-word access via
// read-modify-write, sign/zero extension and misalignment reporting.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      req_valid,
    output logic      req_ready,
    input  logic      req_write,
    input  AccessSize req_size,
    input  logic      req_unsigned,
    input  Register   req_addr,
    input  Register   req_wdata,
    output logic      resp_valid,
    output logic      resp_error,
    output Register   resp_rdata,
    output Register   mem_addr,
    output Signal     mem_read,
    output Signal     mem_write,
    output Register   mem_wdata,
    input  Register   mem_rdata
);

    // Word-aligned, limited to the bits the memory decodes.
    localparam Register MemAddrMask = Register'((64'd1 << ADDR_W) - 64'd1) & ~Register'(32'd3);

    MauState   state;
    Register   addr_q;
    Register   wdata_q;
    Register   rdata_q;
    AccessSize size_q;
    logic      write_q;
    logic      unsigned_q;

    Register   load_data;
    Register   store_word;

    mau_lane_align u_lane_align (
        .rdata       (rdata_q),
        .wdata       (wdata_q),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    // State register plus latched request and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            size_q     <= SIZE_BYTE;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state <= ERR;
                        end else if (!req_write || (req_size != SIZE_WORD)) begin
                            state <= RD;
                        end else begin
                            state <= WR;
                        end
                    end
                end
                RD: begin
                    rdata_q <= mem_rdata;
                    state   <= write_q ? WR : RESP;
                end
                WR:      state <= RESP;
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registers only, so reset clears them (and mem_write) at once.
    assign req_ready  = (state == IDLE);
    assign mem_read   = (state == RD) ? ENABLE : DISABLE;
    assign mem_write  = (state == WR) ? ENABLE : DISABLE;
    assign mem_addr   = ((state == RD) || (state == WR)) ? (addr_q & MemAddrMask) : '0;
    assign mem_wdata  = (state == WR) ? ((size_q == SIZE_WORD) ? wdata_q : store_word) : '0;
    assign resp_valid = (state == RESP) || (state == ERR);
    assign resp_error = (state == ERR);
    assign resp_rdata = ((state == RESP) && !write_q) ? load_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a behavioural word memory.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      req_valid;
    logic      req_ready;
    logic      req_write;
    AccessSize req_size;
    logic      req_unsigned;
    Register   req_addr;
    Register   req_wdata;
    logic      resp_valid;
    logic      resp_error;
    Register   resp_rdata;
    Register   mem_addr;
    Signal     mem_read;
    Signal     mem_write;
    Register   mem_wdata;
    Register   mem_rdata;

    Register   mem [0:(1<<MemAddrWidth)-1];

    int checks;
    int failures;

    mem_access_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_error   (resp_error),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Combinational-read, synchronous-write memory.
    assign mem_rdata = (mem_read == ENABLE) ? mem[mem_addr[MemAddrWidth+1:2]] : 'z;

    always @(posedge clk) begin
        if (mem_write == ENABLE) begin
            mem[mem_addr[MemAddrWidth+1:2]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE; returns in cycle T+1 after the accept edge.
    task automatic issue(input logic w, input AccessSize sz, input logic u,
                         input Register a, input Register d);
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        tick();
        req_valid    = 1'b0;
    endtask

    // Load: read strobe at T+1, response at T+2, then back to IDLE.
    task automatic load_check(input string tag, input AccessSize sz, input logic u,
                              input Register a, input Register exp);
        issue(1'b0, sz, u, a, 32'h0);
        check({tag, "_rd_strobe"}, 32'(mem_read), 32'd1);
        check({tag, "_rd_nowrite"}, 32'(mem_write), 32'd0);
        check({tag, "_rd_addr"}, mem_addr, a & 32'hFFFF_FFFC);
        check({tag, "_rd_noresp"}, 32'(resp_valid), 32'd0);
        tick();
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_resp_error"}, 32'(resp_error), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, exp);
        check({tag, "_resp_nomem"}, 32'({mem_read, mem_write}), 32'd0);
        tick();
        check({tag, "_idle"}, 32'({req_ready, resp_valid}), 32'b10);
    endtask

    task automatic err_check(input string tag, input AccessSize sz, input Register a);
        issue(1'b0, sz, 1'b0, a, 32'h0);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_error"}, 32'(resp_error), 32'd1);
        check({tag, "_rdata"}, resp_rdata, 32'h0);
        check({tag, "_nomem"}, 32'({mem_read, mem_write}), 32'd0);
        tick();
        check({tag, "_idle"}, 32'({req_ready, resp_valid}), 32'b10);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        clk          = 1'b0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = SIZE_WORD;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int i = 0; i < (1 << MemAddrWidth); i++) mem[i] = '0;
        mem[4] = 32'h8899_AABB;

        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp", 32'({resp_valid, resp_error}), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_ctl", 32'({mem_read, mem_write}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        #3 rst_n = 1'b1;
        tick();

        load_check("lw10",  SIZE_WORD, 1'b0, 32'h10, 32'h8899_AABB);
        load_check("lb11",  SIZE_BYTE, 1'b0, 32'h11, 32'hFFFF_FFAA);
        load_check("lbu11", SIZE_BYTE, 1'b1, 32'h11, 32'h0000_00AA);
        load_check("lh12",  SIZE_HALF, 1'b0, 32'h12, 32'hFFFF_8899);
        load_check("lhu12", SIZE_HALF, 1'b1, 32'h12, 32'h0000_8899);
        load_check("lb10",  SIZE_BYTE, 1'b0, 32'h10, 32'hFFFF_FFBB);

        // Sub-word store: RD at T+1, WR at T+2, response at T+3.
        issue(1'b1, SIZE_BYTE, 1'b0, 32'h13, 32'h1234_5677);
        check("sb13_rd", 32'({mem_read, mem_write}), 32'b10);
        tick();
        check("sb13_wr", 32'({mem_read, mem_write}), 32'b01);
        check("sb13_wdata", mem_wdata, 32'h7799_AABB);
        check("sb13_addr", mem_addr, 32'h10);
        tick();
        check("sb13_resp", 32'({resp_valid, resp_error}), 32'b10);
        check("sb13_rdata", resp_rdata, 32'h0);
        tick();
        load_check("lw10_after_sb", SIZE_WORD, 1'b0, 32'h10, 32'h7799_AABB);

        // Word store with req_valid pulsed while busy.
        issue(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'hDEAD_BEEF);
        check("sw20_wr", 32'({mem_read, mem_write}), 32'b01);
        check("sw20_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw20_busy", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        tick();
        check("sw20_resp", 32'({resp_valid, resp_error}), 32'b10);
        check("sw20_busy_resp", 32'(req_ready), 32'd0);
        check("sw20_resp_nomem", 32'({mem_read, mem_write}), 32'd0);
        req_valid = 1'b0;
        tick();
        check("sw20_ignored", 32'({req_ready, resp_valid, mem_read}), 32'b100);
        check("sw20_mem", mem[8], 32'hDEAD_BEEF);
        load_check("lw20", SIZE_WORD, 1'b0, 32'h20, 32'hDEAD_BEEF);

        // Halfword store into the upper half, then reads of the merged word.
        issue(1'b1, SIZE_HALF, 1'b0, 32'h22, 32'hCAFE_1234);
        check("sh22_rd", 32'({mem_read, mem_write}), 32'b10);
        tick();
        check("sh22_wdata", mem_wdata, 32'h1234_BEEF);
        tick();
        check("sh22_resp", 32'({resp_valid, resp_error}), 32'b10);
        tick();
        load_check("lbu23", SIZE_BYTE, 1'b1, 32'h23, 32'h0000_0012);
        load_check("lb20",  SIZE_BYTE, 1'b0, 32'h20, 32'hFFFF_FFEF);

        err_check("lh11_err", SIZE_HALF, 32'h11);
        err_check("lw12_err", SIZE_WORD, 32'h12);
        err_check("lw11_err", SIZE_WORD, 32'h11);

        // Reset during the write phase of a sub-word store.
        issue(1'b1, SIZE_BYTE, 1'b0, 32'h10, 32'h0000_0055);
        tick();
        check("rmw_wr_active", 32'(mem_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rmw_rst_mem_write", 32'(mem_write), 32'd0);
        check("rmw_rst_mem_read", 32'(mem_read), 32'd0);
        check("rmw_rst_req_ready", 32'(req_ready), 32'd1);
        check("rmw_rst_resp", 32'({resp_valid, resp_error}), 32'd0);
        check("rmw_rst_addr", mem_addr, 32'h0);
        check("rmw_rst_wdata", mem_wdata, 32'h0);
        check("rmw_rst_rdata", resp_rdata, 32'h0);
        tick();
        tick();
        check("rmw_mem_unchanged", mem[4], 32'h7799_AABB);
        #3 rst_n = 1'b1;
        tick();
        check("rmw_release_ready", 32'(req_ready), 32'd1);
        load_check("lw10_after_rst", SIZE_WORD, 1'b0, 32'h10, 32'h7799_AABB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
